rv32e_alu: RTL and testbench
============================

// Module: rv32e_alu
// PURPOSE
//  - Integer ALU for the RV32E core execute stage: all RV32I/E register-register and
//    register-immediate arithmetic, logic, compare and shift operations on 32-bit operands.
//  - Decoder supplies a 4-bit op; operand muxing (rs1/rs2/imm/PC) is done upstream.
//  - Result feeds the writeback mux, and the branch/compare logic uses the SLT/SLTU results.
// PARAMETERS
//  - none (XLEN fixed at 32; op width fixed at 4)
// PORTS
//  - clk     in   1   clock; used only when RV32E_ALU_REG_OUT_EN is defined
//  - rst     in   1   synchronous active-high reset; used only when RV32E_ALU_REG_OUT_EN is defined
//  - op      in   4   operation select = {funct7[5], funct3}; encodings below
//  - a       in   32  operand A (rs1 or PC)
//  - b       in   32  operand B (rs2 or immediate)
//  - result  out  32  operation result
// BEHAVIOUR
//  - Op encodings:
//      0000 ADD   a+b, mod 2^32, carry discarded
//      1000 SUB   a-b, mod 2^32
//      0001 SLL   a << b[4:0]
//      0010 SLT   {31'b0, $signed(a) < $signed(b)}
//      0011 SLTU  {31'b0, a < b} (unsigned)
//      0100 XOR   a ^ b
//      0101 SRL   a >> b[4:0], zero fill
//      1101 SRA   a >>> b[4:0], sign fill from a[31]
//      0110 OR    a | b
//      0111 AND   a & b
//      1111 PASSB b (LUI path)
//  - All other codes (1001,1010,1011,1100,1110) yield 32'h0000_0000.
//  - Shift amount uses only b[4:0]; b[31:5] is ignored (shift by 32 acts as shift by 0).
//  - SLT/SLTU: bits [31:1] are always 0.
//  - No flags, no exceptions; overflow is silently wrapped.
//  - The datapath is purely combinational, with no latches; X-free for all defined inputs.
// CONFIGURATION
//  - RV32E_ALU_REG_OUT_EN undefined (default):
//      - result is combinational from op/a/b with zero latency.
//      - clk and rst are present but unused.
//  - RV32E_ALU_REG_OUT_EN defined:
//      - result is registered on the clk rising edge, so it appears one cycle after op/a/b.
//      - rst=1 at an edge forces result to 0; rst takes priority over a new computation.
//      - Output holds between edges; no enable, so the register updates every cycle.
// TESTING
//  - Default (combinational) build: check result after settle delay. Registered build: check
//    one cycle after applying inputs, and check result==0 after rst.
//  - ADD a=7FFF_FFFF b=1 -> 8000_0000; ADD FFFF_FFFF+1 -> 0; SUB a=0 b=1 -> FFFF_FFFF.
//  - SLT a=FFFF_FFFF b=1 -> 1; SLTU same operands -> 0; SLT a=5 b=5 -> 0.
//  - SLL a=1 b=0000_001F -> 8000_0000; SLL a=1 b=0000_0020 -> 1 (only b[4:0] used).
//  - SRL a=8000_0000 b=4 -> 0800_0000; SRA same operands -> F800_0000.
//  - Logic a=F0F0_F0F0 b=0FF0_0FF0: XOR -> FF00_FF00, OR -> FFF0_FFF0, AND -> 00F0_00F0.
//  - PASSB b=1234_5000 -> 1234_5000; undefined op 1010 with any a/b -> 0.

Source files
------------

// File: rtl/rv32e_alu.sv
// RV32E integer ALU: add/sub, shifts, compares, logic ops and LUI pass-through on 32-bit operands.
// Latency: zero (combinational) by default; one clk cycle when RV32E_ALU_REG_OUT_EN is defined.
// Backpressure: none; a new op/a/b is accepted every cycle.
module rv32e_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  // op = {funct7[5], funct3}
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b0001;
  localparam logic [3:0] OP_SLT   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_PASSB = 4'b1111;

  logic [31:0] alu_res;
  logic [4:0]  shamt;

  // Only the low five bits of b select the shift distance.
  assign shamt = b[4:0];

  always_comb begin
    alu_res = 32'h0000_0000;
    case (op)
      OP_ADD:   alu_res = a + b;
      OP_SUB:   alu_res = a - b;
      OP_SLL:   alu_res = a << shamt;
      OP_SLT:   alu_res = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU:  alu_res = {31'b0, a < b};
      OP_XOR:   alu_res = a ^ b;
      OP_SRL:   alu_res = a >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(a) >>> shamt);
      OP_OR:    alu_res = a | b;
      OP_AND:   alu_res = a & b;
      OP_PASSB: alu_res = b;
      default:  alu_res = 32'h0000_0000;
    endcase
  end

`ifdef RV32E_ALU_REG_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= 32'h0000_0000;
    end else begin
      result <= alu_res;
    end
  end
`else
  // clk/rst stay on the port list so both builds share one footprint.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign result = alu_res;
`endif

endmodule

// File: tb/tb_rv32e_alu.sv
// Self-checking bench for rv32e_alu: directed corner vectors plus random ops against an arithmetic reference model.
module tb_rv32e_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rv32e_alu dut (
    .clk    (clk),
    .rst    (rst),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result)
  );

  // Reference built from plain arithmetic: shifts as multiply/divide by powers of two,
  // signed compare via sign-bit bias, arithmetic right shift via complement.
  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] pow2;
    pow2 = 32'd1 << (y % 32);
    case (o)
      4'b0000: return x + y;
      4'b1000: return x + ~y + 32'd1;
      4'b0001: return x * pow2;
      4'b0010: return ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'b0011: return (x < y) ? 32'd1 : 32'd0;
      4'b0100: return x ^ y;
      4'b0101: return x / pow2;
      4'b1101: return x[31] ? ~((~x) / pow2) : x / pow2;
      4'b0110: return x | y;
      4'b0111: return x & y;
      4'b1111: return y;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_now(input string tag, input logic [31:0] exp);
    tests++;
    assert (result === exp) else begin
      fails++;
      $error("FAIL %s op=%b a=%h b=%h got=%h want=%h", tag, op, a, b, result, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] exp);
    op = o;
    a  = x;
    b  = y;
`ifdef RV32E_ALU_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    check_now(tag, exp);
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;

    rst = 1'b1;
    op  = 4'b0000;
    a   = 32'h0000_0000;
    b   = 32'h0000_0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_now("reset", 32'h0000_0000);
    rst = 1'b0;

    step("add_ovf",   4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    step("add_wrap",  4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    step("sub_wrap",  4'b1000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
    step("slt_neg",   4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    step("sltu_big",  4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    step("slt_eq",    4'b0010, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000);
    step("sll_31",    4'b0001, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000);
    step("sll_32",    4'b0001, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001);
    step("srl_4",     4'b0101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000);
    step("sra_4",     4'b1101, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
    step("sra_hi_b",  4'b1101, 32'h8000_0000, 32'hFFFF_FFE4, 32'hF800_0000);
    step("xor",       4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
    step("or",        4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    step("and",       4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    step("passb",     4'b1111, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000);
    step("undef1010", 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    step("undef1001", 4'b1001, 32'h1234_5678, 32'h0000_0003, 32'h0000_0000);
    step("undef1110", 4'b1110, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000);

`ifdef RV32E_ALU_REG_OUT_EN
    // Reset must win over a computation presented on the same edge.
    op  = 4'b0000;
    a   = 32'h0000_0001;
    b   = 32'h0000_0001;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_now("rst_prio", 32'h0000_0000);
    rst = 1'b0;
`endif

    for (int i = 0; i < 400; i++) begin
      ro = 4'($urandom_range(0, 15));
      rx = $urandom;
      ry = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
      step("rand", ro, rx, ry, model(ro, rx, ry));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
